// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI-Lite master: turns one core-side read/write request
// into a complete AXI-Lite transaction and reports read data and response.
module axi_lite_master_ctrl #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  // core side
  input  logic                        i_cpu_req,
  input  logic                        i_cpu_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_cpu_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_cpu_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_cpu_wstrb,
  output logic                        o_cpu_ready,
  output logic                        o_cpu_done,
  output logic [AXI_DATA_WIDTH-1:0]   o_cpu_rdata,
  output logic [1:0]                  o_cpu_resp,
  output logic                        o_cpu_err,
  // write address channel
  output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
  output logic                        o_awvalid,
  input  logic                        i_awready,
  // write data channel
  output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
  output logic                        o_wvalid,
  input  logic                        i_wready,
  // write response channel
  input  logic [1:0]                  i_bresp,
  input  logic                        i_bvalid,
  output logic                        o_bready,
  // read address channel
  output logic [AXI_ADDR_WIDTH-1:0]   o_araddr,
  output logic                        o_arvalid,
  input  logic                        i_arready,
  // read data channel
  input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]                  i_rresp,
  input  logic                        i_rvalid,
  output logic                        o_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP
  } state_t;

  state_t                      r_state;
  logic                        r_ready;
  logic                        r_done;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]                  r_resp;
  logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic                        r_awvalid;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] r_wstrb;
  logic                        r_wvalid;
  logic                        r_bready;
  logic [AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic                        r_arvalid;
  logic                        r_rready;

  // Inside WR_REQ a dropped VALID means that channel has already handshaken.
  logic w_aw_ok;
  logic w_w_ok;
  assign w_aw_ok = !r_awvalid || i_awready;
  assign w_w_ok  = !r_wvalid  || i_wready;

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values; a blocking = would leak new values into later branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= '0;
      r_awaddr  <= '0;
      r_awvalid <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cpu_req) begin
            r_ready <= 1'b0;
            if (i_cpu_we) begin
              r_awaddr  <= i_cpu_addr;
              r_wdata   <= i_cpu_wdata;
              r_wstrb   <= i_cpu_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_araddr  <= i_cpu_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (r_awvalid && i_awready) r_awvalid <= 1'b0;
          if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (i_bvalid) begin
            r_resp   <= i_bresp;
            r_done   <= 1'b1;
            r_bready <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          if (i_rvalid) begin
            r_rdata  <= i_rdata;
            r_resp   <= i_rresp;
            r_done   <= 1'b1;
            r_rready <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cpu_ready = r_ready;
  assign o_cpu_done  = r_done;
  assign o_cpu_rdata = r_rdata;
  assign o_cpu_resp  = r_resp;
  assign o_cpu_err   = r_resp[1];
  assign o_awaddr    = r_awaddr;
  assign o_awvalid   = r_awvalid;
  assign o_wdata     = r_wdata;
  assign o_wstrb     = r_wstrb;
  assign o_wvalid    = r_wvalid;
  assign o_bready    = r_bready;
  assign o_araddr    = r_araddr;
  assign o_arvalid   = r_arvalid;
  assign o_rready    = r_rready;

endmodule

// File: doc/axi_lite_master_ctrl.md
# axi_lite_master_ctrl

Sequencer that turns a single-beat core-side request (address, data, strobes, read/write) into one complete AXI-Lite transaction on a master port. It drives the slave channels through the protocol states and returns read data and the response code to the requester. It sits between the core's load/store/peripheral path and the AXI-Lite peripheral bus, with exactly one transaction in flight.

## Interface
- AXI_DATA_WIDTH, 32, data width of bus and core side
- AXI_ADDR_WIDTH, 4, address width of bus and core side
- Clocking and reset (already decided):
  - clk  in  1  single clock
  - reset  in  1  synchronous, active-high
- Core side:
  - cpu_req  in  1  request strobe, sampled only while cpu_ready=1
  - cpu_we  in  1  1=write, 0=read
  - cpu_addr  in  AXI_ADDR_WIDTH  byte address
  - cpu_wdata  in  AXI_DATA_WIDTH  write data
  - cpu_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes
  - cpu_ready  out  1  controller idle, request may be issued
  - cpu_done  out  1  one-cycle completion pulse
  - cpu_rdata  out  AXI_DATA_WIDTH  read data, valid with cpu_done on reads, held until next done
  - cpu_resp  out  2  BRESP/RRESP of the completed transaction, held until next done
  - cpu_err  out  1  cpu_resp[1], i.e. SLVERR/DECERR, valid with cpu_done
- AXI-Lite master: AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out. Widths follow the parameters; resp fields are 2 bits.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE: cpu_ready=1. On cpu_req=1, register addr/wdata/wstrb and go to WR_REQ if cpu_we=1, else RD_REQ. cpu_req in any other state is ignored. There is no queue.
- WR_REQ:
  - AWVALID and WVALID both 1 on entry.
  - Each drops on the cycle after its own handshake (VALID&READY). The two handshakes may occur in either order or in the same cycle.
  - When both handshakes are done, go to WR_RESP.
  - AWADDR/WDATA/WSTRB are stable while their VALID is high.
- WR_RESP: BREADY=1. On BVALID, capture BRESP, pulse cpu_done, return to IDLE.
- RD_REQ: ARVALID=1 with registered address. On ARREADY, go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA/RRESP, pulse cpu_done, return to IDLE.
- Read transactions leave the write channels untouched, and vice versa.
- VALID is never withdrawn before its handshake.
- A nonzero resp is reported through cpu_err only. There is no retry.

## Timing
- Reset values (the first edge with reset=1 forces these):
  - state=IDLE, cpu_ready=1, cpu_done=0
  - cpu_rdata=0, cpu_resp=0, cpu_err=0
  - all VALID and READY outputs 0
  - AWADDR/ARADDR/WDATA/WSTRB 0
- Reset mid-transaction abandons it immediately. No cpu_done is produced. The bus slave is reset by the same signal.
- Request accepted at edge 0; VALIDs are high in cycle 1.
- Write with AW/W/B all ready at once: handshakes in cycle 1, BREADY in cycle 2, BVALID in cycle 2. cpu_done and cpu_ready are high in cycle 3. Minimum write latency is 3 cycles.
- Read with ARREADY and RVALID immediate: ARVALID in cycle 1, RREADY in cycle 2, cpu_done in cycle 3.
- cpu_done is registered and coincides with the first IDLE cycle. A new cpu_req in that same cycle is accepted: back-to-back throughput is one transaction per 3 cycles minimum.
- Each wait state on the slave side adds exactly one cycle.
- BREADY/RREADY are 0 outside their response states. A stray BVALID/RVALID there is not consumed.

## Test plan
- Write, addr=0x4, wdata=0xDEADBEEF, wstrb=0xF, all slave readys high -> AW/W handshake in cycle 1, cpu_done in cycle 3 with cpu_resp=0 and cpu_err=0.
- Write where WREADY comes 2 cycles before AWREADY -> WVALID drops after its handshake, AWVALID is held with stable AWADDR, BREADY asserts only after the AW handshake.
- Read, addr=0x8, ARREADY delayed 2 cycles, RVALID 3 cycles after the AR handshake with RDATA=0x12345678 -> cpu_done with cpu_rdata=0x12345678; cpu_ready=0 throughout.
- Write returning BRESP=2'b10 -> cpu_done with cpu_resp=2 and cpu_err=1. The following read with RRESP=0 clears cpu_err.
- Reset asserted while in WR_REQ with AWVALID=1 -> next cycle all VALIDs 0, cpu_ready=1, no cpu_done.
- Back-to-back read then write, with cpu_req held high in the cpu_done cycle -> second request is accepted there, with no idle gap.
